// File: rtl/mbc3_controller.sv
// MBC3 cartridge bank controller: ROM/RAM bank registers and address mapping.
// Define MBC3_RTC_EN to build the real-time clock; without it the RTC is absent.
module mbc3_controller #(
    parameter int ROM_ADDR_WIDTH    = 21,
    parameter int RAM_ADDR_WIDTH    = 15,
    parameter int RTC_TICKS_PER_SEC = 4194304
) (
    input  logic                      core_clk,
    input  logic                      reset,
    input  logic [15:0]               cpu_addr,
    input  logic [7:0]                cpu_data_in,
    input  logic                      cpu_wr,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      rtc_sel,
    output logic [7:0]                rtc_data_out,
    output logic [6:0]                rom_bank_dbg
);

    logic       ram_en_q, ram_en_d;
    logic [6:0] rom_bank_q, rom_bank_d;
    logic [3:0] bank_sel_q, bank_sel_d;
    logic       latch_prev_q, latch_prev_d;

    logic [2:0] region;
    logic       in_ram_win;
    logic       wr_latch;

    // Each 8 KiB slice of the address map is one register or window.
    assign region     = cpu_addr[15:13];
    assign in_ram_win = (region == 3'd5);
    assign wr_latch   = cpu_wr && (region == 3'd3);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ram_en_d     = ram_en_q;
        rom_bank_d   = rom_bank_q;
        bank_sel_d   = bank_sel_q;
        latch_prev_d = latch_prev_q;
        if (cpu_wr) begin
            case (region)
                3'd0: ram_en_d   = (cpu_data_in[3:0] == 4'hA);
                3'd1: rom_bank_d = (cpu_data_in[6:0] == 7'h00) ? 7'h01 : cpu_data_in[6:0];
                3'd2: bank_sel_d = cpu_data_in[3:0];
                3'd3: latch_prev_d = (cpu_data_in == 8'h01);
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            ram_en_q     <= 1'b0;
            rom_bank_q   <= 7'h01;
            bank_sel_q   <= 4'h0;
            latch_prev_q <= 1'b1;
        end else begin
            ram_en_q     <= ram_en_d;
            rom_bank_q   <= rom_bank_d;
            bank_sel_q   <= bank_sel_d;
            latch_prev_q <= latch_prev_d;
        end
    end

    assign rom_addr     = (cpu_addr[15:14] == 2'b01) ? {rom_bank_q, cpu_addr[13:0]}
                                                     : {7'h00, cpu_addr[13:0]};
    assign ram_cs       = in_ram_win && ram_en_q && (bank_sel_q[3:2] == 2'b00);
    assign ram_addr     = {bank_sel_q[1:0], cpu_addr[12:0]};
    assign ram_we       = ram_cs && cpu_wr;
    assign rom_bank_dbg = rom_bank_q;

`ifdef MBC3_RTC_EN
    localparam int PRE_W = (RTC_TICKS_PER_SEC > 1) ? $clog2(RTC_TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RTC_TICKS_PER_SEC - 1);

    typedef struct packed {
        logic       carry;
        logic       halt;
        logic [8:0] day;
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } rtc_t;

    rtc_t             live_q, live_d, lat_q, lat_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             rtc_access, rtc_wr, latch_fire;
    logic [7:0]       rtc_byte;

    assign rtc_access = in_ram_win && ram_en_q && (bank_sel_q >= 4'h8) && (bank_sel_q <= 4'hC);
    assign rtc_wr     = rtc_access && cpu_wr;
    assign latch_fire = wr_latch && (cpu_data_in == 8'h01) && !latch_prev_q;

    always_comb begin
        live_d = live_q;
        lat_d  = lat_q;
        pre_d  = pre_q;
        if (!live_q.halt) begin
            if (pre_q == PRE_MAX) begin
                pre_d       = '0;
                live_d.sec  = live_q.sec + 6'd1;
                if (live_q.sec == 6'd59) begin
                    live_d.sec = '0;
                    live_d.min = live_q.min + 6'd1;
                    if (live_q.min == 6'd59) begin
                        live_d.min = '0;
                        live_d.hr  = live_q.hr + 5'd1;
                        if (live_q.hr == 5'd23) begin
                            live_d.hr  = '0;
                            live_d.day = live_q.day + 9'd1;
                            if (live_q.day == 9'd511) live_d.carry = 1'b1;
                        end
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        // The CPU write is applied after the tick so it overrides the same field.
        if (rtc_wr) begin
            case (bank_sel_q[2:0])
                3'd0: begin
                    live_d.sec = cpu_data_in[5:0];
                    pre_d      = '0;
                end
                3'd1: live_d.min      = cpu_data_in[5:0];
                3'd2: live_d.hr       = cpu_data_in[4:0];
                3'd3: live_d.day[7:0] = cpu_data_in;
                3'd4: begin
                    live_d.carry  = cpu_data_in[7];
                    live_d.halt   = cpu_data_in[6];
                    live_d.day[8] = cpu_data_in[0];
                end
                default: ;
            endcase
        end
        if (latch_fire) lat_d = live_q;
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            live_q <= '0;
            lat_q  <= '0;
            pre_q  <= '0;
        end else begin
            live_q <= live_d;
            lat_q  <= lat_d;
            pre_q  <= pre_d;
        end
    end

    always_comb begin
        case (bank_sel_q[2:0])
            3'd0:    rtc_byte = {2'b00, lat_q.sec};
            3'd1:    rtc_byte = {2'b00, lat_q.min};
            3'd2:    rtc_byte = {3'b000, lat_q.hr};
            3'd3:    rtc_byte = lat_q.day[7:0];
            3'd4:    rtc_byte = {lat_q.carry, lat_q.halt, 5'b00000, lat_q.day[8]};
            default: rtc_byte = 8'h00;
        endcase
    end

    assign rtc_sel      = rtc_access;
    assign rtc_data_out = rtc_access ? rtc_byte : 8'hFF;
`else
    assign rtc_sel      = 1'b0;
    assign rtc_data_out = 8'hFF;
`endif

endmodule

// File: tb/tb_mbc3_controller.sv
// Bench for mbc3_controller: fixed vector table, random traffic against an
// arithmetic reference model, and hand-written RTC and reset sequences.
module tb_mbc3_controller;

    localparam int TICKS = 4;
`ifdef MBC3_RTC_EN
    localparam bit HAS_RTC = 1'b1;
`else
    localparam bit HAS_RTC = 1'b0;
`endif

    logic        clk, rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic [20:0] rom_addr;
    logic [14:0] ram_addr;
    logic        ram_cs, ram_we, rtc_sel;
    logic [7:0]  rtc_data_out;
    logic [6:0]  rom_bank_dbg;

    int vectors = 0;
    int miscompares = 0;

    mbc3_controller #(
        .ROM_ADDR_WIDTH   (21),
        .RAM_ADDR_WIDTH   (15),
        .RTC_TICKS_PER_SEC(TICKS)
    ) dut (
        .core_clk    (clk),
        .reset       (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_wr      (cpu_wr),
        .rom_addr    (rom_addr),
        .ram_addr    (ram_addr),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .rtc_sel     (rtc_sel),
        .rtc_data_out(rtc_data_out),
        .rom_bank_dbg(rom_bank_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_ram_en, m_rom_bank, m_bank_sel, m_latch_prev, m_pre;
    int m_sec, m_min, m_hr, m_day, m_halt, m_carry;
    int m_lat[5];
    int snap[5];

    function automatic int live_byte(input int i);
        case (i)
            0: return m_sec;
            1: return m_min;
            2: return m_hr;
            3: return m_day % 256;
            default: return m_carry * 128 + m_halt * 64 + m_day / 256;
        endcase
    endfunction

    task automatic advance_second();
        if (m_sec != 59) m_sec = (m_sec + 1) % 64;
        else begin
            m_sec = 0;
            if (m_min != 59) m_min = (m_min + 1) % 64;
            else begin
                m_min = 0;
                if (m_hr != 23) m_hr = (m_hr + 1) % 32;
                else begin
                    m_hr = 0;
                    if (m_day == 511) begin
                        m_day   = 0;
                        m_carry = 1;
                    end else m_day = m_day + 1;
                end
            end
        end
    endtask

    task automatic rtc_write(input int idx, input int d);
        case (idx)
            0: begin m_sec = d % 64; m_pre = 0; end
            1: m_min = d % 64;
            2: m_hr  = d % 32;
            3: m_day = (m_day / 256) * 256 + d;
            default: begin
                m_carry = d / 128;
                m_halt  = (d / 64) % 2;
                m_day   = (m_day % 256) + (d % 2) * 256;
            end
        endcase
    endtask

    task automatic model_step();
        int d;
        if (rst) begin
            m_ram_en = 0; m_rom_bank = 1; m_bank_sel = 0; m_latch_prev = 1; m_pre = 0;
            m_sec = 0; m_min = 0; m_hr = 0; m_day = 0; m_halt = 0; m_carry = 0;
            for (int i = 0; i < 5; i++) m_lat[i] = 0;
        end else begin
            d = int'(cpu_data_in);
            for (int i = 0; i < 5; i++) snap[i] = live_byte(i);
            if (HAS_RTC && m_halt == 0) begin
                if (m_pre == TICKS - 1) begin
                    m_pre = 0;
                    advance_second();
                end else m_pre = m_pre + 1;
            end
            if (cpu_wr) begin
                case (int'(cpu_addr) / 8192)
                    0: m_ram_en = (d % 16 == 10) ? 1 : 0;
                    1: m_rom_bank = (d % 128 == 0) ? 1 : d % 128;
                    2: m_bank_sel = d % 16;
                    3: begin
                        if (d == 1 && m_latch_prev == 0)
                            for (int i = 0; i < 5; i++) m_lat[i] = snap[i];
                        m_latch_prev = (d == 1) ? 1 : 0;
                    end
                    5: if (HAS_RTC && m_ram_en == 1 && m_bank_sel >= 8 && m_bank_sel <= 12)
                           rtc_write(m_bank_sel - 8, d);
                    default: ;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        int a;
        bit in_ram, cs, rs;
        logic [20:0] e_rom;
        logic [14:0] e_ram;
        logic [7:0]  e_rtc;
        a      = int'(cpu_addr);
        e_rom  = (a >= 16'h4000 && a < 16'h8000) ? 21'(m_rom_bank * 16384 + a % 16384)
                                                 : 21'(a % 16384);
        e_ram  = 15'((m_bank_sel % 4) * 8192 + a % 8192);
        in_ram = (a >= 16'hA000 && a < 16'hC000);
        cs     = in_ram && m_ram_en == 1 && m_bank_sel < 4;
        rs     = HAS_RTC && in_ram && m_ram_en == 1 && m_bank_sel >= 8 && m_bank_sel <= 12;
        e_rtc  = rs ? 8'(m_lat[m_bank_sel - 8]) : 8'hFF;
        check(name,
              64'({rom_addr, ram_addr, ram_cs, ram_we, rtc_sel, rtc_data_out, rom_bank_dbg}),
              64'({e_rom, e_ram, cs, cs && cpu_wr, rs, e_rtc, 7'(m_rom_bank)}));
    endtask

    task automatic apply(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(negedge clk);
        cpu_addr    = a;
        cpu_data_in = d;
        cpu_wr      = w;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        apply(a, d, 1'b1);
        check_model("model_wr");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(16'h0150, 8'h00, 1'b0);
            check_model("model_idle");
        end
    endtask

    task automatic rtc_read(input logic [3:0] bank, input logic [7:0] exp, input string name);
        wr(16'h4000, {4'h0, bank});
        apply(16'hA000, 8'h00, 1'b0);
        check_model("model_rtc_read");
        check(name, 64'({rtc_sel, rtc_data_out}), 64'({1'b1, exp}));
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic [20:0] rom;
        logic [14:0] ram;
        logic        cs;
        logic        we;
        logic [6:0]  dbg;
    } vec_t;

    vec_t vt[22];
    int   r;
    logic [15:0] ra;
    logic [7:0]  rd;

    initial begin
        vt[0]  = '{16'h4123, 8'h00, 1'b0, 21'h004123, 15'h0123, 1'b0, 1'b0, 7'h01};
        vt[1]  = '{16'h2000, 8'h7F, 1'b1, 21'h002000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[2]  = '{16'h7FFF, 8'h00, 1'b0, 21'h1FFFFF, 15'h1FFF, 1'b0, 1'b0, 7'h7F};
        vt[3]  = '{16'h2100, 8'h00, 1'b1, 21'h002100, 15'h0100, 1'b0, 1'b0, 7'h7F};
        vt[4]  = '{16'h4000, 8'h00, 1'b0, 21'h004000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[5]  = '{16'h0000, 8'h0A, 1'b1, 21'h000000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[6]  = '{16'h4000, 8'h02, 1'b1, 21'h004000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[7]  = '{16'hA005, 8'h55, 1'b1, 21'h002005, 15'h4005, 1'b1, 1'b1, 7'h01};
        vt[8]  = '{16'hB000, 8'h00, 1'b0, 21'h003000, 15'h5000, 1'b1, 1'b0, 7'h01};
        vt[9]  = '{16'h0000, 8'h00, 1'b1, 21'h000000, 15'h4000, 1'b0, 1'b0, 7'h01};
        vt[10] = '{16'hA005, 8'h55, 1'b1, 21'h002005, 15'h4005, 1'b0, 1'b0, 7'h01};
        vt[11] = '{16'h1FFF, 8'h1A, 1'b1, 21'h001FFF, 15'h5FFF, 1'b0, 1'b0, 7'h01};
        vt[12] = '{16'h5000, 8'h04, 1'b1, 21'h005000, 15'h5000, 1'b0, 1'b0, 7'h01};
        vt[13] = '{16'hA000, 8'h00, 1'b0, 21'h002000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[14] = '{16'h4000, 8'h13, 1'b1, 21'h004000, 15'h0000, 1'b0, 1'b0, 7'h01};
        vt[15] = '{16'hBFFF, 8'hAA, 1'b1, 21'h003FFF, 15'h7FFF, 1'b1, 1'b1, 7'h01};
        vt[16] = '{16'hC000, 8'h00, 1'b0, 21'h000000, 15'h6000, 1'b0, 1'b0, 7'h01};
        vt[17] = '{16'h3FFF, 8'h80, 1'b1, 21'h003FFF, 15'h7FFF, 1'b0, 1'b0, 7'h01};
        vt[18] = '{16'h5ABC, 8'h00, 1'b0, 21'h005ABC, 15'h7ABC, 1'b0, 1'b0, 7'h01};
        vt[19] = '{16'h2000, 8'h85, 1'b1, 21'h002000, 15'h6000, 1'b0, 1'b0, 7'h01};
        vt[20] = '{16'h4001, 8'h00, 1'b0, 21'h014001, 15'h6001, 1'b0, 1'b0, 7'h05};
        vt[21] = '{16'hFFFF, 8'h00, 1'b1, 21'h003FFF, 15'h7FFF, 1'b0, 1'b0, 7'h05};

        rst = 1'b1;
        cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_wr = 1'b0;
        apply(16'h4123, 8'h00, 1'b0);
        check("reset_state",
              64'({rom_addr, ram_cs, ram_we, rtc_sel, rtc_data_out, rom_bank_dbg}),
              64'({21'h004123, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h01}));
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            apply(vt[i].addr, vt[i].data, vt[i].wr);
            check($sformatf("table[%0d]", i),
                  64'({rom_addr, ram_addr, ram_cs, ram_we, rtc_sel, rtc_data_out, rom_bank_dbg}),
                  64'({vt[i].rom, vt[i].ram, vt[i].cs, vt[i].we, 1'b0, 8'hFF, vt[i].dbg}));
            check_model("model_table");
        end

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: begin ra = {3'd0, 13'($urandom)}; rd = ($urandom_range(0, 2) != 0) ? 8'h0A : 8'($urandom); end
                1: begin ra = {3'd1, 13'($urandom)}; rd = 8'($urandom); end
                2, 3: begin
                    ra = {3'd2, 13'($urandom)};
                    rd = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8, 12)) : 8'($urandom);
                end
                4: begin ra = {3'd3, 13'($urandom)}; rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1)); end
                5, 6, 7: begin ra = {3'd5, 13'($urandom)}; rd = 8'($urandom); end
                default: begin ra = 16'($urandom); rd = 8'($urandom); end
            endcase
            apply(ra, rd, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            check_model("model_random");
        end

`ifdef MBC3_RTC_EN
        // Full rollover: 23:59:59 on day 511 ticks into day 0 with carry.
        wr(16'h0000, 8'h0A);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h41);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h09); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h0A); wr(16'hA000, 8'd23);
        wr(16'h4000, 8'h0B); wr(16'hA000, 8'hFF);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h01);
        idle(4);
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
        rtc_read(4'hC, 8'h80, "rollover_ctrl");
        rtc_read(4'h8, 8'h00, "rollover_sec");
        rtc_read(4'h9, 8'h00, "rollover_min");
        rtc_read(4'hA, 8'h00, "rollover_hr");
        rtc_read(4'hB, 8'h00, "rollover_day");

        // Halt freezes the clock; a lone 0x01 latch write does not latch.
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h40);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'h25);
        idle(100);
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
        rtc_read(4'h8, 8'h25, "halt_sec");
        wr(16'hA000, 8'h10);
        wr(16'h6000, 8'h01);
        rtc_read(4'h8, 8'h25, "no_latch_without_zero");
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
        rtc_read(4'h8, 8'h10, "relatch_sec");

        // Out-of-range seconds wrap 63->0 without carrying into minutes.
        wr(16'h4000, 8'h09); wr(16'hA000, 8'd7);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd63);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h00);
        idle(4);
        wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
        rtc_read(4'h8, 8'h00, "wrap63_sec");
        rtc_read(4'h9, 8'h07, "wrap63_min");
`else
        wr(16'h0000, 8'h0A);
        wr(16'h4000, 8'h08);
        apply(16'hA000, 8'h00, 1'b0);
        check_model("model_no_rtc");
        check("no_rtc_read", 64'({rtc_sel, ram_cs, rtc_data_out}), 64'({1'b0, 1'b0, 8'hFF}));
        apply(16'hA000, 8'h33, 1'b1);
        check("no_rtc_write", 64'({rtc_sel, ram_cs, ram_we}), 64'({1'b0, 1'b0, 1'b0}));
`endif

        // A half-finished latch sequence must not survive reset.
        wr(16'h2000, 8'h33);
        wr(16'h6000, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply(16'h4000, 8'h00, 1'b0);
        check("reset_mid_bank", 64'({rom_bank_dbg, rom_addr}), 64'({7'h01, 21'h004000}));
        idle(10);
        wr(16'h6000, 8'h01);
        wr(16'h0000, 8'h0A);
`ifdef MBC3_RTC_EN
        rtc_read(4'h8, 8'h00, "reset_clears_latch_seq");
`else
        wr(16'h4000, 8'h08);
        apply(16'hA000, 8'h00, 1'b0);
        check_model("model_after_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
